// File: rtl/ft2232h_rx_if.sv
// Bus bundle for the FT2232H receive engine: the FTDI 245-sync read-side
// pins plus the downstream valid/ready byte stream.
interface ft2232h_rx_if;
  logic       rxf_n;
  logic [7:0] data_in;
  logic       oe_n;
  logic       rd_n;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // Engine side: reads the FTDI chip, sources the byte stream.
  modport master (
    input  rxf_n,
    input  data_in,
    input  out_ready,
    output oe_n,
    output rd_n,
    output out_data,
    output out_valid
  );

  // Peer side: FTDI chip model / downstream sink.
  modport slave (
    output rxf_n,
    output data_in,
    output out_ready,
    input  oe_n,
    input  rd_n,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/ft2232h_rx.sv
// FT2232H 245 synchronous FIFO receive engine. Runs an IDLE -> OE -> READ
// burst on the FTDI bus, captures one byte per READ edge with RXF# low, and
// buffers the bytes in a first-word-fall-through FIFO drained downstream.
module ft2232h_rx #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  ft2232h_rx_if.master     bus,
  output logic             busy,
  output logic [CNT_W-1:0] rx_count
);

  localparam int AW = $clog2(DEPTH);

  // Start a burst only with room for the byte captured on the exit edge.
  localparam logic [AW:0] FILL_START_MAX = (AW+1)'(DEPTH - 2);
  // Leaving at DEPTH-1 still leaves room for the byte written on that edge.
  localparam logic [AW:0] FILL_EXIT_MIN  = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OE   = 2'd1,
    READ = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic          push;
  logic          pop;
  logic          read_exit;

  // A byte is taken exactly on edges where RD# is low and RXF# is low.
  assign push = (state == READ) && !bus.rxf_n;
  assign pop  = bus.out_valid && bus.out_ready;

  // Exit uses the registered fill only; a concurrent pop is ignored so the
  // decision stays conservative.
  assign read_exit = bus.rxf_n || !enable || (fill >= FILL_EXIT_MIN);

  // Fall-through head: the memory is read combinationally so a byte written
  // at an edge is on the port right after that edge.
  assign bus.out_valid = (fill != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 8'h00;

  // Burst FSM with registered OE#/RD#/busy derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bus.oe_n <= 1'b1;
      bus.rd_n <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !bus.rxf_n && (fill <= FILL_START_MAX)) begin
            state    <= OE;
            bus.oe_n <= 1'b0;
            bus.rd_n <= 1'b1;
            busy     <= 1'b1;
          end
        end
        OE: begin
          if (!bus.rxf_n) begin
            state    <= READ;
            bus.oe_n <= 1'b0;
            bus.rd_n <= 1'b0;
            busy     <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.oe_n <= 1'b1;
            bus.rd_n <= 1'b1;
            busy     <= 1'b0;
          end
        end
        READ: begin
          if (read_exit) begin
            state    <= IDLE;
            bus.oe_n <= 1'b1;
            bus.rd_n <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.oe_n <= 1'b1;
          bus.rd_n <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers, fill level and received-byte counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      rx_count <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        rx_count <= rx_count + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        fill <= fill + (AW+1)'(1);
      end else if (pop && !push) begin
        fill <= fill - (AW+1)'(1);
      end
    end
  end

  // Byte storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

endmodule
